alu_exec_stage: RTL and testbench

- EX-stage arithmetic unit of the pipelined 16-bit CPU.
- Consumes the 6-bit ALU control code produced by the ALU control decoder, together with the operands and link PC.
- Computes the result and branch condition, and registers them into the EX/MEM boundary through a 2-entry skid buffer with valid/ready handshakes on both sides.
- Supports pipeline flush on branch/jump mispredict.

---
 rtl/alu_exec_stage.sv | 131 +++++++++++++
 tb/tb_alu_exec_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// EX-stage ALU of the 16-bit pipeline: computes result/branch condition and
// registers it into the EX/MEM boundary through a 2-entry skid buffer.
module alu_exec_stage #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           alu_control,
  input  logic [WORD_SIZE-1:0] op_a,
  input  logic [WORD_SIZE-1:0] op_b,
  input  logic [WORD_SIZE-1:0] pc_next,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_result,
  output logic                 out_bcond,
  output logic                 out_illegal
);

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_AND  = 6'd2;
  localparam logic [5:0] ALU_ORR  = 6'd3;
  localparam logic [5:0] ALU_NOT  = 6'd4;
  localparam logic [5:0] ALU_TCP  = 6'd5;
  localparam logic [5:0] ALU_SHL  = 6'd6;
  localparam logic [5:0] ALU_SHR  = 6'd7;
  localparam logic [5:0] ALU_LHI  = 6'd8;
  localparam logic [5:0] ALU_BNE  = 6'd9;
  localparam logic [5:0] ALU_BEQ  = 6'd10;
  localparam logic [5:0] ALU_BGZ  = 6'd11;
  localparam logic [5:0] ALU_BLZ  = 6'd12;
  localparam logic [5:0] ALU_LINK = 6'd13;
  localparam logic [5:0] ALU_WWD  = 6'd28;
  localparam logic [5:0] ALU_HLT  = 6'd29;

  // Entry layout: {illegal, bcond, result}
  localparam int EW = WORD_SIZE + 2;

  logic [WORD_SIZE-1:0] result_next;
  logic [WORD_SIZE-1:0] diff;
  logic                 bcond_next;
  logic                 illegal_next;
  logic [EW-1:0]        entry_next;

  logic [EW-1:0]        out_entry_reg;
  logic                 out_valid_reg;
  logic [EW-1:0]        skid_entry_reg;
  logic                 skid_valid_reg;

  logic                 accept;
  logic                 advance;

  always_comb begin
    result_next  = '0;
    bcond_next   = 1'b0;
    illegal_next = 1'b0;
    diff         = op_a - op_b;
    case (alu_control)
      ALU_ADD:  result_next = op_a + op_b;
      ALU_SUB:  result_next = diff;
      ALU_AND:  result_next = op_a & op_b;
      ALU_ORR:  result_next = op_a | op_b;
      ALU_NOT:  result_next = ~op_a;
      ALU_TCP:  result_next = -op_a;
      ALU_SHL:  result_next = op_a << 1;
      ALU_SHR:  result_next = $unsigned($signed(op_a) >>> 1);
      ALU_LHI:  result_next[WORD_SIZE-1 -: 8] = op_b[7:0];
      ALU_BNE: begin
        result_next = diff;
        bcond_next  = (op_a != op_b);
      end
      ALU_BEQ: begin
        result_next = diff;
        bcond_next  = (op_a == op_b);
      end
      ALU_BGZ: begin
        result_next = diff;
        bcond_next  = ~op_a[WORD_SIZE-1] & (|op_a);
      end
      ALU_BLZ: begin
        result_next = diff;
        bcond_next  = op_a[WORD_SIZE-1];
      end
      ALU_LINK: result_next = pc_next;
      ALU_WWD:  result_next = op_a;
      ALU_HLT:  result_next = '0;
      default:  illegal_next = 1'b1;
    endcase
    entry_next = {illegal_next, bcond_next, result_next};
  end

  // in_ready comes only from the skid flag, so out_ready never reaches it.
  assign in_ready = ~skid_valid_reg;
  assign accept   = in_valid & in_ready;
  assign advance  = ~out_valid_reg | out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_reg  <= 1'b0;
      out_entry_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_entry_reg <= '0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (advance) begin
      if (skid_valid_reg) begin
        out_entry_reg  <= skid_entry_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        out_entry_reg <= entry_next;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      skid_entry_reg <= entry_next;
      skid_valid_reg <= 1'b1;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_result  = out_entry_reg[WORD_SIZE-1:0];
  assign out_bcond   = out_entry_reg[WORD_SIZE];
  assign out_illegal = out_entry_reg[WORD_SIZE+1];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed test-plan vectors plus a
// randomized run scored against a queue-based reference model.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  alu_control;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] pc_next;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_bcond;
  logic        out_illegal;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .op_a(op_a), .op_b(op_b), .pc_next(pc_next),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_bcond(out_bcond), .out_illegal(out_illegal)
  );

  // Reference: returns {illegal, bcond, result}
  function automatic logic [17:0] model(input logic [5:0] code, input logic [15:0] a,
                                        input logic [15:0] b, input logic [15:0] pc);
    logic [15:0] r;
    logic        bc;
    logic        il;
    r = 16'd0; bc = 1'b0; il = 1'b0;
    case (code)
      6'd0:  r = a + b;
      6'd1:  r = a - b;
      6'd2:  r = a & b;
      6'd3:  r = a | b;
      6'd4:  r = 16'hFFFF ^ a;
      6'd5:  r = 16'd0 - a;
      6'd6:  r = a * 16'd2;
      6'd7:  r = (a / 16'd2) | (a & 16'h8000);
      6'd8:  r = (b & 16'h00FF) * 16'd256;
      6'd9:  begin r = a - b; bc = (a != b); end
      6'd10: begin r = a - b; bc = (a == b); end
      6'd11: begin r = a - b; bc = ($signed(a) > 0); end
      6'd12: begin r = a - b; bc = ($signed(a) < 0); end
      6'd13: r = pc;
      6'd28: r = a;
      6'd29: r = 16'd0;
      default: il = 1'b1;
    endcase
    return {il, bc, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] code, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] pc);
    alu_control = code; op_a = a; op_b = b; pc_next = pc;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    drive(6'd0, 16'h0001, 16'h0002, 16'h0000);
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_result !== 16'h0 || out_bcond !== 1'b0 ||
        out_illegal !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_state: got v=%b r=%h b=%b i=%b rdy=%b, want 0 0000 0 0 1",
               out_valid, out_result, out_bcond, out_illegal, in_ready);
    else passes++;
    reset_n = 1'b1; in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_discard: got out_valid=%b, want 0", out_valid);
    else passes++;
    $display("reset: done");
  endtask

  task automatic run_op(input string name, input logic [5:0] code, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] pc,
                        input logic [15:0] er, input logic eb, input logic ei);
    drive(code, a, b, pc);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL %s_ready: got in_ready=%b, want 1", name, in_ready);
    else passes++;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== er || out_bcond !== eb || out_illegal !== ei)
      $display("FAIL %s: got v=%b r=%h b=%b i=%b, want v=1 r=%h b=%b i=%b",
               name, out_valid, out_result, out_bcond, out_illegal, er, eb, ei);
    else passes++;
    $display("op %s code=%0d a=%h b=%h -> r=%h b=%b i=%b", name, code, a, b,
             out_result, out_bcond, out_illegal);
  endtask

  task automatic test_ops();
    run_op("add",  6'd0,  16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 1'b0, 1'b0);
    run_op("shr",  6'd7,  16'h8004, 16'h0000, 16'h0000, 16'hC002, 1'b0, 1'b0);
    run_op("shl",  6'd6,  16'h8001, 16'h0000, 16'h0000, 16'h0002, 1'b0, 1'b0);
    run_op("lhi",  6'd8,  16'h0000, 16'h00AB, 16'h0000, 16'hAB00, 1'b0, 1'b0);
    run_op("tcp",  6'd5,  16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    run_op("bgz",  6'd11, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_op("blz",  6'd12, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    run_op("beq",  6'd10, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op("bne",  6'd9,  16'h1234, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0);
    run_op("link", 6'd13, 16'h5555, 16'h6666, 16'h0042, 16'h0042, 1'b0, 1'b0);
    run_op("hlt",  6'd29, 16'h5555, 16'h6666, 16'h0042, 16'h0000, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; flush = 1'b0; in_valid = 1'b1;
    drive(6'd0, 16'd1, 16'd1, 16'd0);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL bp_first_ready: got %b, want 1", in_ready);
    else passes++;
    tick();
    drive(6'd3, 16'd5, 16'd2, 16'd0);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== 16'd2)
      $display("FAIL bp_second: got rdy=%b v=%b r=%h, want 1 1 0002", in_ready, out_valid, out_result);
    else passes++;
    tick();
    drive(6'd1, 16'd9, 16'd4, 16'd0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 16'd2)
        $display("FAIL bp_stall%0d: got rdy=%b v=%b r=%h, want 0 1 0002",
                 k, in_ready, out_valid, out_result);
      else passes++;
      if (k < 2) tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'd7 || in_ready !== 1'b1)
      $display("FAIL bp_out2: got v=%b r=%h rdy=%b, want 1 0007 1", out_valid, out_result, in_ready);
    else passes++;
    $display("bp: result %h", out_result);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'd5)
      $display("FAIL bp_out3: got v=%b r=%h, want 1 0005", out_valid, out_result);
    else passes++;
    $display("bp: result %h", out_result);
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty: got v=%b, want 0", out_valid);
    else passes++;
  endtask

  task automatic test_flush();
    drain();
    out_ready = 1'b0; in_valid = 1'b1;
    drive(6'd28, 16'h1111, 16'h0, 16'h0); tick();
    drive(6'd28, 16'h2222, 16'h0, 16'h0); tick();
    checks++;
    if (in_ready !== 1'b0) $display("FAIL flush_skid_full: got rdy=%b, want 0", in_ready);
    else passes++;
    flush = 1'b1;
    drive(6'd28, 16'h3333, 16'h0, 16'h0); tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_full: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
    else passes++;
    flush = 1'b0;
    drive(6'd28, 16'h4444, 16'h0, 16'h0); tick();
    flush = 1'b1;
    drive(6'd28, 16'h5555, 16'h0, 16'h0); tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_open: got v=%b rdy=%b, want 0 1", out_valid, in_ready);
    else passes++;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b0)
        $display("FAIL flush_leak%0d: got v=%b r=%h, want v=0", k, out_valid, out_result);
      else passes++;
      tick();
    end
    $display("flush: done");
    run_op("post_flush", 6'd0, 16'h0101, 16'h0101, 16'h0, 16'h0202, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_illegal_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    drive(6'd20, 16'h1234, 16'h5678, 16'h0); tick();
    checks++;
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_result !== 16'h0 || out_bcond !== 1'b0)
      $display("FAIL illegal: got v=%b i=%b r=%h b=%b, want 1 1 0000 0",
               out_valid, out_illegal, out_result, out_bcond);
    else passes++;
    $display("illegal: code 20 -> i=%b r=%h", out_illegal, out_result);
    drive(6'd0, 16'd3, 16'd4, 16'h0); tick();
    in_valid = 1'b0; tick();
    reset_n = 1'b0; in_valid = 1'b1; tick();
    checks++;
    if (out_valid !== 1'b0 || out_result !== 16'h0 || out_bcond !== 1'b0 ||
        out_illegal !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_reset: got v=%b r=%h b=%b i=%b rdy=%b, want 0 0000 0 0 1",
               out_valid, out_result, out_bcond, out_illegal, in_ready);
    else passes++;
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL stall_reset_skid: got v=%b, want 0", out_valid);
    else passes++;
  endtask

  task automatic test_random();
    logic [17:0] sb[$];
    logic [17:0] held;
    logic [17:0] exp;
    logic        hold_chk;
    hold_chk = 1'b0;
    held = '0;
    drain();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) alu_control = 6'($urandom_range(0, 63));
      else                           alu_control = 6'($urandom_range(0, 13));
      op_a    = 16'($urandom);
      op_b    = ($urandom_range(0, 3) == 0) ? op_a : 16'($urandom);
      pc_next = 16'($urandom);
      checks++;
      if (in_ready !== (sb.size() < 2))
        $display("FAIL rnd_ready@%0d: got %b, want %b", i, in_ready, sb.size() < 2);
      else passes++;
      if (hold_chk) begin
        checks++;
        if (out_valid !== 1'b1 || {out_illegal, out_bcond, out_result} !== held)
          $display("FAIL rnd_stable@%0d: got v=%b %h, want v=1 %h", i, out_valid,
                   {out_illegal, out_bcond, out_result}, held);
        else passes++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (sb.size() == 0)
          $display("FAIL rnd_extra@%0d: got r=%h with nothing outstanding", i, out_result);
        else begin
          exp = sb.pop_front();
          if ({out_illegal, out_bcond, out_result} !== exp)
            $display("FAIL rnd_data@%0d: got %h, want %h", i,
                     {out_illegal, out_bcond, out_result}, exp);
          else passes++;
          $display("rnd %0d: out %h", i, {out_illegal, out_bcond, out_result});
        end
      end
      hold_chk = (out_valid === 1'b1) && !out_ready;
      held     = {out_illegal, out_bcond, out_result};
      if (in_valid && in_ready === 1'b1)
        sb.push_back(model(alu_control, op_a, op_b, pc_next));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0)
          $display("FAIL rnd_drain_extra: got r=%h with nothing outstanding", out_result);
        else begin
          exp = sb.pop_front();
          if ({out_illegal, out_bcond, out_result} !== exp)
            $display("FAIL rnd_drain: got %h, want %h", {out_illegal, out_bcond, out_result}, exp);
          else passes++;
        end
      end
      tick();
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0)
      $display("FAIL rnd_lost: got %0d entries outstanding v=%b, want 0 0", sb.size(), out_valid);
    else passes++;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    drive(6'd0, 16'h0, 16'h0, 16'h0);
    test_reset();
    test_ops();
    test_backpressure();
    test_flush();
    test_illegal_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
